temp_sense_ctrl: RTL and testbench

- Measurement sequencer for the on-chip temperature sensor. The sensor is a temperature-dependent ring oscillator whose output reaches this block as an asynchronous digital signal.
- Powers the sensor up, waits a settle time, then counts oscillator rising edges over a programmable gate window timed by clk.
- Publishes the count as the raw temperature code.
- Sits between the top-level pin logic (start/config from ui_in, result to uo_out/uio_out) and the analog sensor enable.

---
 rtl/temp_sense_ctrl.sv | 155 +++++++++++++++
 tb/tb_temp_sense_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/temp_sense_ctrl.sv
// Ring-oscillator temperature sensor sequencer: power up, settle, count
// synchronized oscillator edges over a 2^(gate+4) cycle window, publish count.
module temp_sense_ctrl #(
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic [3:0]       gate_log2,
    input  logic             osc_in,
    output logic             sensor_en,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overflow
);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int WIN_W = 15;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         gate_q, gate_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               sat_q, sat_d;
    logic               sensor_en_q, sensor_en_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               overflow_q, overflow_d;
    logic               sync1_q, sync2_q, hist_q;
    logic               edge_det;
    logic [3:0]         gate_clamped;

    function automatic logic [WIN_W-1:0] win_last(input logic [3:0] g);
        logic [15:0] len;
        len = 16'd1 << (5'(g) + 5'd4);
        return WIN_W'(len - 16'd1);
    endfunction

    assign gate_clamped = (gate_log2 > 4'd11) ? 4'd11 : gate_log2;
    assign edge_det     = sync2_q & ~hist_q;

    always_comb begin
        state_d        = state_q;
        gate_d         = gate_q;
        settle_d       = settle_q;
        win_d          = win_q;
        edge_cnt_d     = edge_cnt_q;
        sat_d          = sat_q;
        sensor_en_d    = sensor_en_q;
        result_d       = result_q;
        overflow_d     = overflow_q;
        result_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                sensor_en_d = 1'b0;
                if (start) begin
                    gate_d      = gate_clamped;
                    settle_d    = SET_W'(SETTLE_CYCLES - 1);
                    sensor_en_d = 1'b1;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    win_d      = win_last(gate_q);
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    state_d    = MEASURE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            MEASURE: begin
                // An edge arriving at full scale is lost; that is what sat records.
                if (edge_det) begin
                    if (edge_cnt_q == {CNT_W{1'b1}}) sat_d = 1'b1;
                    else                             edge_cnt_d = edge_cnt_q + 1'b1;
                end
                if (win_q == '0) state_d = DONE;
                else             win_d   = win_q - 1'b1;
            end
            DONE: begin
                result_d       = edge_cnt_q;
                overflow_d     = sat_q;
                result_valid_d = 1'b1;
                if (continuous) begin
                    gate_d     = gate_clamped;
                    win_d      = win_last(gate_clamped);
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    state_d    = MEASURE;
                end else begin
                    sensor_en_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over every transition but lets a DONE publish its result.
        if (stop) begin
            state_d     = IDLE;
            sensor_en_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            gate_q         <= '0;
            settle_q       <= '0;
            win_q          <= '0;
            edge_cnt_q     <= '0;
            sat_q          <= 1'b0;
            sensor_en_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            hist_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gate_q         <= gate_d;
            settle_q       <= settle_d;
            win_q          <= win_d;
            edge_cnt_q     <= edge_cnt_d;
            sat_q          <= sat_d;
            sensor_en_q    <= sensor_en_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
            sync1_q        <= osc_in;
            sync2_q        <= sync1_q;
            hist_q         <= sync2_q;
        end
    end

    assign sensor_en    = sensor_en_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_temp_sense_ctrl.sv
// Randomized bench for temp_sense_ctrl; a 16-bit and a 4-bit instance share stimulus
// and are checked against edge counts taken from the recorded oscillator samples.
module tb_temp_sense_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, continuous = 1'b0, osc_in = 1'b0;
    logic [3:0]  gate_log2 = 4'd0;
    logic        sensor_en, busy, result_valid, overflow;
    logic [15:0] result;
    logic        s_sensor_en, s_busy, s_result_valid, s_overflow;
    logic [3:0]  s_result;

    temp_sense_ctrl #(.CNT_W(16), .SETTLE_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .gate_log2(gate_log2), .osc_in(osc_in), .sensor_en(sensor_en), .busy(busy),
        .result(result), .result_valid(result_valid), .overflow(overflow));

    temp_sense_ctrl #(.CNT_W(4), .SETTLE_CYCLES(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .gate_log2(gate_log2), .osc_in(osc_in), .sensor_en(s_sensor_en), .busy(s_busy),
        .result(s_result), .result_valid(s_result_valid), .overflow(s_overflow));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    bit osc_s [0:131071];
    int osc_per = 4, osc_ph = 0;
    int nrv = 0, exp_rv = 0;

    // osc_s[n] holds osc_in as seen at posedge number n.
    always @(posedge clk) begin
        osc_s[cyc] = osc_in;
        cyc = cyc + 1;
    end

    // osc_per: 0 = hold, 1 = random bit per cycle, >=2 = square wave of that period.
    always @(negedge clk) begin
        if (result_valid) nrv++;
        if (osc_per == 1) osc_in = 1'($urandom);
        else if (osc_per >= 2) begin
            osc_ph++;
            if (osc_ph >= osc_per / 2) begin
                osc_ph = 0;
                osc_in = ~osc_in;
            end
        end
    end

    task automatic chk(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int win(input int g);
        return 1 << (((g > 11) ? 11 : g) + 4);
    endfunction

    // Rising edges seen through a 2-flop synchronizer and history flop, counted at posedges a..b.
    function automatic int cnt(input int a, input int b);
        int s = 0;
        for (int k = a; k <= b; k++) s += (osc_s[k-2] && !osc_s[k-3]) ? 1 : 0;
        return s;
    endfunction

    task automatic to_edge(input int n);
        while (cyc < n + 1) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input int c);
        chk({tag, "_rv"}, result_valid, 1);
        chk({tag, "_res"}, result, (c > 65535) ? 65535 : c);
        chk({tag, "_ov"}, overflow, 0);
        chk({tag, "_res4"}, s_result, (c > 15) ? 15 : c);
        chk({tag, "_ov4"}, s_overflow, (c > 15) ? 1 : 0);
        exp_rv++;
    endtask

    task automatic launch(input int g, output int e);
        e = cyc;
        start = 1'b1;
        gate_log2 = 4'(g);
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_en", sensor_en, 1);
    endtask

    task automatic run_single(input string tag, input int g, input bit poke);
        int e, w;
        launch(g, e);
        w = win(g);
        if (poke) begin
            to_edge(e + 5);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        gate_log2 = 4'($urandom);
        to_edge(e + 16 + w);
        chk({tag, "_done_busy"}, busy, 1);
        chk({tag, "_done_rv"}, result_valid, 0);
        to_edge(e + 17 + w);
        check_result(tag, cnt(e + 17, e + 16 + w));
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_en"}, sensor_en, 0);
        @(negedge clk);
        chk({tag, "_rv_pulse"}, result_valid, 0);
    endtask

    task automatic run_cont(input int n);
        int e, m, w, gn;
        continuous = 1'b1;
        launch($urandom_range(0, 2), e);
        m = e + 16;
        w = win(int'(gate_log2));
        for (int i = 0; i < n; i++) begin
            to_edge(m + w);
            chk("cont_done_en", sensor_en, 1);
            gn = $urandom_range(0, 3);
            gate_log2 = 4'(gn);
            if (i == n - 1) continuous = 1'b0;
            to_edge(m + w + 1);
            check_result("cont", cnt(m + 1, m + w));
            chk("cont_en", sensor_en, (i == n - 1) ? 0 : 1);
            chk("cont_busy", busy, (i == n - 1) ? 0 : 1);
            m = m + w + 1;
            w = win(gn);
        end
        @(negedge clk);
    endtask

    initial begin
        int e, r, nr;
        repeat (3) @(negedge clk);
        chk("rst_en", sensor_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_ov", overflow, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        osc_per = 4;  run_single("single_p4", 2, 1'b0);
        osc_per = 1;
        for (int i = 0; i < 3; i++) run_single("single_rand", $urandom_range(0, 3), 1'b1);
        osc_per = 2;  run_single("sat_p2", 2, 1'b0);
        osc_per = 32; run_single("nosat_p32", 2, 1'b0);
        osc_per = 4;  run_cont(5);
        osc_per = 1;  run_cont(4);

        // Abort mid-window: no result, prior result kept.
        launch(2, e);
        to_edge(e + 36);
        r = result; nr = nrv;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_en", sensor_en, 0);
        repeat (80) @(negedge clk);
        chk("abort_res", result, r);
        chk("abort_rv_cnt", nrv, nr);

        // Abort landing on the DONE cycle still publishes.
        launch(1, e);
        to_edge(e + 16 + win(1));
        stop = 1'b1;
        to_edge(e + 17 + win(1));
        stop = 1'b0;
        check_result("abort_done", cnt(e + 17, e + 16 + win(1)));
        chk("abort_done_busy", busy, 0);
        @(negedge clk);

        // Asynchronous reset mid-measurement.
        launch(3, e);
        to_edge(e + 40);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en", sensor_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_res", result, 0);
        chk("arst_rv", result_valid, 0);
        chk("arst_ov4", s_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_idle", busy, 0);

        osc_per = 1;  run_single("clamp15", 15, 1'b0);
        repeat (3) @(negedge clk);
        chk("rv_pulses", nrv, exp_rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
